// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if: host, probe, FIFO and drain-stream signals of the capture sequencer.
// The master modport is the sequencer itself. The slave modport is the environment,
// meaning the probe pins, the host registers, the FIFO and the stream consumer.
interface capture_ctrl_if;
  // Probe and host control
  logic [7:0] probe;
  logic       arm;
  logic       abort;
  logic [7:0] div;
  logic [7:0] trig_mask;
  logic [7:0] trig_value;
  // FIFO side
  logic [7:0] fifo_wdata;
  logic       fifo_wen;
  logic       fifo_ren;
  logic [7:0] fifo_rdata;
  logic       fifo_valid;
  // Drain stream to the host
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  // Status
  logic       busy;
  logic       done;

  modport master (
    input  probe, arm, abort, div, trig_mask, trig_value,
    input  fifo_rdata, fifo_valid, out_ready,
    output fifo_wdata, fifo_wen, fifo_ren, out_data, out_valid, busy, done
  );

  modport slave (
    output probe, arm, abort, div, trig_mask, trig_value,
    output fifo_rdata, fifo_valid, out_ready,
    input  fifo_wdata, fifo_wen, fifo_ren, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl: sequencer for the analyzer's 8-bit sample FIFO.
// The sequence is arm, then a masked trigger on the probe bus, then a burst of DEPTH
// prescaled samples written into the FIFO. After that the FIFO is drained over a
// valid/ready stream. An abort flushes the FIFO back to empty.
// Optional feature: CAPTURE_CTRL_EDGE_TRIG_EN selects an edge trigger, which fires when
// any masked bit changed since the previous strobe. The default is a level/match trigger.
module capture_ctrl #(
  parameter int unsigned DEPTH = 4  // samples per capture, equal to FIFO depth (2..15)
) (
  input  logic           clk,
  input  logic           rst_n,
  capture_ctrl_if.master bus
);

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN,
    ST_FLUSH
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] presc_q, presc_d;
  // Samples written while capturing. The same register then counts down the samples
  // still to be read during DRAIN.
  logic [3:0] count_q, count_d;
  logic [7:0] wdata_q, wdata_d;
  logic       wen_q, wen_d;
  logic       ren_q, ren_d;      // ren_q high means a read is in flight
  logic       out_valid_q, out_valid_d;
  logic       done_q, done_d;
  // fresh_q marks the cycle in which fifo_rdata carries the sample just read.
  // hold_q keeps that sample for as long as the host stalls.
  logic       fresh_q, fresh_d;
  logic [7:0] hold_q, hold_d;

  logic       running;
  logic       strobe;
  logic       trig_hit;

  assign running = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign strobe  = running && (presc_q == bus.div);

`ifdef CAPTURE_CTRL_EDGE_TRIG_EN
  logic [7:0] prev_q, prev_d;
  logic       seen_q, seen_d;   // a previous ARMED strobe exists to compare against

  assign trig_hit = seen_q && (((bus.probe ^ prev_q) & bus.trig_mask) != 8'h00);
`else
  assign trig_hit = ((bus.probe & bus.trig_mask) == (bus.trig_value & bus.trig_mask));
`endif

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case, so that no path can infer a latch.
    state_d     = state_q;
    presc_d     = running ? (strobe ? 8'h00 : presc_q + 8'h01) : 8'h00;
    count_d     = count_q;
    wdata_d     = wdata_q;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    fresh_d     = 1'b0;
    hold_d      = fresh_q ? bus.fifo_rdata : hold_q;
`ifdef CAPTURE_CTRL_EDGE_TRIG_EN
    prev_d      = prev_q;
    seen_d      = seen_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.arm) begin
          state_d = ST_ARMED;
          count_d = 4'd0;
`ifdef CAPTURE_CTRL_EDGE_TRIG_EN
          seen_d  = 1'b0;
`endif
        end
      end

      ST_ARMED: begin
        if (bus.abort) begin
          state_d = ST_FLUSH;
        end else if (strobe) begin
`ifdef CAPTURE_CTRL_EDGE_TRIG_EN
          prev_d = bus.probe;
          seen_d = 1'b1;
`endif
          if (trig_hit) begin
            // The trigger sample itself becomes entry 0.
            wen_d   = 1'b1;
            wdata_d = bus.probe;
            count_d = 4'd1;
            state_d = ST_CAPTURE;
          end
        end
      end

      ST_CAPTURE: begin
        if (bus.abort) begin
          state_d = ST_FLUSH;
        end else if (strobe) begin
          wen_d   = 1'b1;
          wdata_d = bus.probe;
          count_d = count_q + 4'd1;
          if (count_q + 4'd1 == DEPTH_C) begin
            state_d = ST_DRAIN;   // count_q now equals DEPTH, which is the number still to drain
          end
        end
      end

      ST_DRAIN: begin
        if (bus.abort) begin
          state_d     = ST_FLUSH;
          out_valid_d = 1'b0;
        end else if (ren_q) begin
          out_valid_d = 1'b1;
          fresh_d     = 1'b1;
          count_d     = count_q - 4'd1;
        end else if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          if (count_q == 4'd0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (!out_valid_q && (count_q != 4'd0)) begin
          ren_d = 1'b1;
        end
      end

      ST_FLUSH: begin
        // Pop every other cycle, so that fifo_valid has settled after each read.
        out_valid_d = 1'b0;
        if (!ren_q) begin
          if (bus.fifo_valid) begin
            ren_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      presc_q     <= 8'h00;
      count_q     <= 4'd0;
      wdata_q     <= 8'h00;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      fresh_q     <= 1'b0;
      hold_q      <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments, so that every register samples pre-edge values.
      state_q     <= state_d;
      presc_q     <= presc_d;
      count_q     <= count_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      fresh_q     <= fresh_d;
      hold_q      <= hold_d;
    end
  end

`ifdef CAPTURE_CTRL_EDGE_TRIG_EN
  // Previous-strobe sample used by the edge trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 8'h00;
      seen_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      seen_q <= seen_d;
    end
  end
`endif

  assign bus.fifo_wdata = wdata_q;
  assign bus.fifo_wen   = wen_q;
  assign bus.fifo_ren   = ren_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = fresh_q ? bus.fifo_rdata : hold_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;

endmodule
